// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage access engine: funct3 access codes and FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_pkg;

  // Access size and extension codes, taken from instr[14:12].
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering: store byte enables and replicated data, misalignment check, load extraction/extension.
// Latency: purely combinational.
// Backpressure: none; the caller decides when outputs are used.
module load_store_align
  import mem_pkg::*;
(
  input  logic [2:0]  st_funct3_i,   // size of the access about to be issued
  input  logic [1:0]  addr_lo_i,     // byte offset of the access about to be issued
  input  logic [31:0] store_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o,
  input  logic [2:0]  ld_funct3_i,   // size/extension of the access in flight
  input  logic [1:0]  ld_offset_i,   // byte offset of the access in flight
  input  logic [31:0] rdata_i,
  output logic [31:0] load_data_o
);

  logic [31:0] ld_shifted;

  // Move the addressed byte/half down to bit 0 before extension.
  assign ld_shifted = rdata_i >> {ld_offset_i, 3'b000};

  // Store lanes and alignment; unsized funct3 codes fall back to word behaviour.
  always_comb begin
    be_o       = 4'b1111;
    wdata_o    = store_data_i;
    misalign_o = 1'b0;
    case (st_funct3_i)
      F3_B, F3_BU: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      F3_H, F3_HU: begin
        be_o       = 4'b0011 << addr_lo_i;
        wdata_o    = {2{store_data_i[15:0]}};
        misalign_o = addr_lo_i[0];
      end
      default: begin
        be_o       = 4'b1111;
        wdata_o    = store_data_i;
        misalign_o = |addr_lo_i;
      end
    endcase
  end

  // Load extension; any code other than the sub-word ones returns the whole word.
  always_comb begin
    load_data_o = rdata_i;
    case (ld_funct3_i)
      F3_B:    load_data_o = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      F3_H:    load_data_o = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      F3_BU:   load_data_o = {24'h0, ld_shifted[7:0]};
      F3_HU:   load_data_o = {16'h0, ld_shifted[15:0]};
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage engine: runs EX/MEM loads/stores over a req/ack data-memory port and registers the MEM/WB outputs.
// Latency: non-memory op 1 cycle; memory op 2 cycles minimum (1 IDLE cycle + BUSY until ack or timeout).
// Backpressure: stall_o holds EX/MEM while an access is outstanding; upstream advances on the ack/timeout edge.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] VALUResult_i,
  input  logic [31:0] RDData_i,
  input  logic [4:0]  RDaddr_i,
  input  logic        RegWrite_i,
  input  logic        MemToReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] instr_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic        valid_o,
  output logic        RegWrite_o,
  output logic        MemToReg_o,
  output logic [4:0]  RDaddr_o,
  output logic [31:0] ALUResult_o,
  output logic [31:0] VALUResult_o,
  output logic [31:0] MemData_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] tmo_cnt_q;

  logic        valid_q;
  logic        regwrite_q;
  logic        memtoreg_q;
  logic [4:0]  rdaddr_q;
  logic [31:0] alu_q;
  logic [31:0] valu_q;
  logic [31:0] memdata_q;
  logic        misalign_q;
  logic        buserr_q;

  logic [2:0]  funct3;
  logic        mem_op;
  logic        is_store;
  logic        busy;
  logic        misalign;
  logic        misalign_drop;
  logic        start_d;
  logic        done_d;
  logic        timeout_hit;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] load_data;
  logic        unused_instr;

  assign funct3        = instr_i[14:12];
  assign unused_instr  = ^{instr_i[31:15], instr_i[11:0]};
  assign mem_op        = valid_i & (MemRead_i | MemWrite_i);
  // Read wins when both control bits are set.
  assign is_store      = MemWrite_i & ~MemRead_i;
  assign busy          = (state_q == ST_BUSY);
  assign misalign_drop = ~busy & mem_op & misalign;
  assign start_d       = ~busy & mem_op & ~misalign;
  assign timeout_hit   = TMO_EN & busy & ~dmem_ack_i & (tmo_cnt_q == TMO_LAST);
  assign done_d        = busy & (dmem_ack_i | timeout_hit);

  load_store_align u_align (
    .st_funct3_i  (funct3),
    .addr_lo_i    (ALUResult_i[1:0]),
    .store_data_i (RDData_i),
    .be_o         (be),
    .wdata_o      (wdata),
    .misalign_o   (misalign),
    .ld_funct3_i  (funct3_q),
    .ld_offset_i  (addr_q[1:0]),
    .rdata_i      (dmem_rdata_i),
    .load_data_o  (load_data)
  );

  // Stall is combinational so the EX/MEM register holds on the same edge the access starts.
  assign stall_o = busy ? (~dmem_ack_i & ~timeout_hit) : start_d;

  // Memory port is driven only from latched values while BUSY, and quiet otherwise.
  assign dmem_req_o   = busy;
  assign dmem_we_o    = busy & we_q;
  assign dmem_addr_o  = busy ? {addr_q[31:2], 2'b00} : 32'h0;
  assign dmem_wdata_o = busy ? wdata_q : 32'h0;
  assign dmem_be_o    = busy ? be_q : 4'h0;

  assign valid_o      = valid_q;
  assign RegWrite_o   = regwrite_q;
  assign MemToReg_o   = memtoreg_q;
  assign RDaddr_o     = rdaddr_q;
  assign ALUResult_o  = alu_q;
  assign VALUResult_o = valu_q;
  assign MemData_o    = memdata_q;
  assign misalign_o   = misalign_q;
  assign bus_err_o    = buserr_q;

  // Access FSM together with the registered MEM/WB outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      be_q       <= 4'h0;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      tmo_cnt_q  <= 32'h0;
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      rdaddr_q   <= 5'h0;
      alu_q      <= 32'h0;
      valu_q     <= 32'h0;
      memdata_q  <= 32'h0;
      misalign_q <= 1'b0;
      buserr_q   <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      buserr_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_d) begin
            state_q   <= ST_BUSY;
            addr_q    <= ALUResult_i;
            wdata_q   <= wdata;
            be_q      <= be;
            we_q      <= is_store;
            funct3_q  <= funct3;
            tmo_cnt_q <= 32'h0;
            valid_q   <= 1'b0;
          end else begin
            // Pass-through; a misaligned access is dropped but still retires with no write-back.
            valid_q    <= valid_i;
            regwrite_q <= RegWrite_i & ~misalign_drop;
            memtoreg_q <= MemToReg_i;
            rdaddr_q   <= RDaddr_i;
            alu_q      <= ALUResult_i;
            valu_q     <= VALUResult_i;
            memdata_q  <= 32'h0;
            misalign_q <= misalign_drop;
          end
        end
        ST_BUSY: begin
          if (done_d) begin
            // EX/MEM is still held here, so the pass-through fields come straight from the inputs.
            state_q    <= ST_IDLE;
            tmo_cnt_q  <= 32'h0;
            valid_q    <= 1'b1;
            regwrite_q <= RegWrite_i & ~timeout_hit;
            memtoreg_q <= MemToReg_i;
            rdaddr_q   <= RDaddr_i;
            alu_q      <= ALUResult_i;
            valu_q     <= VALUResult_i;
            memdata_q  <= (dmem_ack_i & ~we_q) ? load_data : 32'h0;
            buserr_q   <= timeout_hit;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 32'd1;
            valid_q   <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table driven through the req/ack port, scoreboard on MEM/WB outputs.
// Latency: checks 1-cycle pass-through and multi-cycle BUSY stalls, timeout and reset-in-BUSY.
// Backpressure: emulates upstream hold by keeping EX/MEM inputs stable while stall_o is high.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [31:0] alu_i, valu_i, rddata_i, instr_i, rdata_i;
  logic [4:0]  rdaddr_i;
  logic        rw_i, m2r_i, mr_i, mw_i, ack_i;
  logic        req_o, we_o, stall_o, valid_o, rw_o, m2r_o, mis_o, berr_o;
  logic [31:0] addr_o, wdata_o, alu_o, valu_o, memdata_o;
  logic [3:0]  be_o;
  logic [4:0]  rdaddr_o;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i),
    .ALUResult_i(alu_i), .VALUResult_i(valu_i), .RDData_i(rddata_i), .RDaddr_i(rdaddr_i),
    .RegWrite_i(rw_i), .MemToReg_i(m2r_i), .MemRead_i(mr_i), .MemWrite_i(mw_i), .instr_i(instr_i),
    .dmem_req_o(req_o), .dmem_we_o(we_o), .dmem_addr_o(addr_o), .dmem_wdata_o(wdata_o), .dmem_be_o(be_o),
    .dmem_ack_i(ack_i), .dmem_rdata_i(rdata_i),
    .stall_o(stall_o), .valid_o(valid_o), .RegWrite_o(rw_o), .MemToReg_o(m2r_o), .RDaddr_o(rdaddr_o),
    .ALUResult_o(alu_o), .VALUResult_o(valu_o), .MemData_o(memdata_o),
    .misalign_o(mis_o), .bus_err_o(berr_o)
  );

  typedef struct {
    string       name;
    logic        rw, m2r, mr, mw;
    logic [2:0]  f3;
    logic [31:0] addr, sdata, rdata;
    int          ack_after;   // BUSY cycles before ack (large = never)
    int          exp_stalls;
    logic        exp_req, exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_rw, exp_mis, exp_berr;
    logic [31:0] exp_mem;
  } vec_t;

  typedef struct {
    string       name;
    logic        rw, m2r, mis, berr;
    logic [4:0]  rd;
    logic [31:0] alu, valu, mem;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[14];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic rw, m2r, mr, mw, input logic [2:0] f3,
                              input logic [31:0] addr, sdata, rdata, input int ack_after, stalls,
                              input logic req, we, input logic [3:0] be, input logic [31:0] wd,
                              input logic erw, emis, eberr, input logic [31:0] emem);
    vec_t v;
    v.name = n; v.rw = rw; v.m2r = m2r; v.mr = mr; v.mw = mw; v.f3 = f3;
    v.addr = addr; v.sdata = sdata; v.rdata = rdata; v.ack_after = ack_after;
    v.exp_stalls = stalls; v.exp_req = req; v.exp_we = we; v.exp_be = be; v.exp_wdata = wd;
    v.exp_rw = erw; v.exp_mis = emis; v.exp_berr = eberr; v.exp_mem = emem;
    return v;
  endfunction

  task automatic clear_inputs();
    valid_i = 0; alu_i = 0; valu_i = 0; rddata_i = 0; instr_i = 0; rdata_i = 0;
    rdaddr_i = 0; rw_i = 0; m2r_i = 0; mr_i = 0; mw_i = 0; ack_i = 0;
  endtask

  // Scoreboard side: every retired MEM/WB entry must match the oldest expectation.
  always @(negedge clk) begin
    if (valid_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_valid_o", 32'(valid_o), 32'h0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk({e.name, ".RegWrite_o"},   32'(rw_o),     32'(e.rw));
        chk({e.name, ".MemToReg_o"},   32'(m2r_o),    32'(e.m2r));
        chk({e.name, ".RDaddr_o"},     32'(rdaddr_o), 32'(e.rd));
        chk({e.name, ".ALUResult_o"},  alu_o,         e.alu);
        chk({e.name, ".VALUResult_o"}, valu_o,        e.valu);
        chk({e.name, ".MemData_o"},    memdata_o,     e.mem);
        chk({e.name, ".misalign_o"},   32'(mis_o),    32'(e.mis));
        chk({e.name, ".bus_err_o"},    32'(berr_o),   32'(e.berr));
      end
    end else if ((mis_o === 1'b1) || (berr_o === 1'b1)) begin
      chk("pulse_without_valid", {30'h0, mis_o, berr_o}, 32'h0);
    end
  end

  task automatic run_vec(input int i);
    vec_t v;
    exp_t e;
    int   busy_n, stalls;
    bit   seen_req, done;
    v = vecs[i];
    @(posedge clk); #1;
    valid_i = 1; alu_i = v.addr; valu_i = 32'h5000_0000 + 32'(i); rddata_i = v.sdata;
    rdaddr_i = 5'(i + 1); rw_i = v.rw; m2r_i = v.m2r; mr_i = v.mr; mw_i = v.mw;
    instr_i = {17'h0, v.f3, 12'h0}; ack_i = 0;
    e.name = v.name; e.rw = v.exp_rw; e.m2r = v.m2r; e.mis = v.exp_mis; e.berr = v.exp_berr;
    e.rd = 5'(i + 1); e.alu = v.addr; e.valu = 32'h5000_0000 + 32'(i); e.mem = v.exp_mem;
    sb_q.push_back(e);
    busy_n = 0; stalls = 0; seen_req = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        ack_i = 0;
      end
      if (req_o === 1'b1) begin
        if (!seen_req) begin
          chk({v.name, ".dmem_addr_o"}, addr_o, {v.addr[31:2], 2'b00});
          chk({v.name, ".dmem_we_o"}, 32'(we_o), 32'(v.exp_we));
          if (v.exp_we) begin
            chk({v.name, ".dmem_be_o"}, 32'(be_o), 32'(v.exp_be));
            chk({v.name, ".dmem_wdata_o"}, wdata_o, v.exp_wdata);
          end
        end
        seen_req = 1;
        if (busy_n == v.ack_after) begin
          ack_i = 1;
          rdata_i = v.rdata;
        end
        busy_n++;
      end
      @(negedge clk);
      if (stall_o === 1'b1) stalls++;
      else done = 1;
    end
    if (!done) chk({v.name, ".stall_timeout"}, 32'h1, 32'h0);
    chk({v.name, ".stall_cycles"}, 32'(stalls), 32'(v.exp_stalls));
    chk({v.name, ".req_seen"}, 32'(seen_req), 32'(v.exp_req));
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
  endtask

  initial begin
    //            name      rw m2r mr mw f3      addr         sdata        rdata        ack stl req we be       wdata         rw mis ber mem
    vecs[0]  = mk("add",    1, 0, 0, 0, 3'b000, 32'h1234,    32'h0,       32'h0,       0,  0,  0, 0, 4'h0,    32'h0,         1, 0, 0, 32'h0);
    vecs[1]  = mk("lb",     1, 1, 1, 0, 3'b000, 32'h103,     32'h0,       32'h80FFFF00, 3, 4,  1, 0, 4'h0,    32'h0,         1, 0, 0, 32'hFFFFFF80);
    vecs[2]  = mk("lbu",    1, 1, 1, 0, 3'b100, 32'h103,     32'h0,       32'h80FFFF00, 1, 2,  1, 0, 4'h0,    32'h0,         1, 0, 0, 32'h00000080);
    vecs[3]  = mk("sh",     0, 0, 0, 1, 3'b001, 32'h102,     32'h0000ABCD, 32'h0,      0,  1,  1, 1, 4'b1100, 32'hABCDABCD,  0, 0, 0, 32'h0);
    vecs[4]  = mk("lw_mis", 1, 1, 1, 0, 3'b010, 32'h102,     32'h0,       32'h0,       0,  0,  0, 0, 4'h0,    32'h0,         0, 1, 0, 32'h0);
    vecs[5]  = mk("lh",     1, 1, 1, 0, 3'b001, 32'h102,     32'h0,       32'h80011234, 0, 1,  1, 0, 4'h0,    32'h0,         1, 0, 0, 32'hFFFF8001);
    vecs[6]  = mk("lhu",    1, 1, 1, 0, 3'b101, 32'h100,     32'h0,       32'h1234F00D, 2, 3,  1, 0, 4'h0,    32'h0,         1, 0, 0, 32'h0000F00D);
    vecs[7]  = mk("lw",     1, 1, 1, 0, 3'b010, 32'h204,     32'h0,       32'hDEADBEEF, 0, 1,  1, 0, 4'h0,    32'h0,         1, 0, 0, 32'hDEADBEEF);
    vecs[8]  = mk("sb",     0, 0, 0, 1, 3'b000, 32'h101,     32'h1234565A, 32'h0,      0,  1,  1, 1, 4'b0010, 32'h5A5A5A5A,  0, 0, 0, 32'h0);
    vecs[9]  = mk("sw",     0, 0, 0, 1, 3'b010, 32'h108,     32'hCAFEF00D, 32'h0,      1,  2,  1, 1, 4'b1111, 32'hCAFEF00D,  0, 0, 0, 32'h0);
    vecs[10] = mk("sh_mis", 0, 0, 0, 1, 3'b001, 32'h103,     32'h0000ABCD, 32'h0,      0,  0,  0, 0, 4'h0,    32'h0,         0, 1, 0, 32'h0);
    vecs[11] = mk("lw_tmo", 1, 1, 1, 0, 3'b010, 32'h10,      32'h0,       32'h55555555, 99, 4, 1, 0, 4'h0,    32'h0,         0, 0, 1, 32'h0);
    vecs[12] = mk("rd_wr",  1, 1, 1, 1, 3'b010, 32'h0,       32'hFFFFFFFF, 32'h11223344, 0, 1, 1, 0, 4'h0,    32'h0,         1, 0, 0, 32'h11223344);
    vecs[13] = mk("lw_f3x", 1, 1, 1, 0, 3'b011, 32'h8,       32'h0,       32'hA5A50F0F, 0, 1,  1, 0, 4'h0,    32'h0,         1, 0, 0, 32'hA5A50F0F);

    clear_inputs();
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset.valid_o",     32'(valid_o), 32'h0);
    chk("reset.stall_o",     32'(stall_o), 32'h0);
    chk("reset.dmem_req_o",  32'(req_o),   32'h0);
    chk("reset.RegWrite_o",  32'(rw_o),    32'h0);
    chk("reset.MemData_o",   memdata_o,    32'h0);
    chk("reset.misalign_o",  32'(mis_o),   32'h0);
    chk("reset.bus_err_o",   32'(berr_o),  32'h0);

    for (int i = 0; i < 14; i++) run_vec(i);

    // Reset while BUSY: the access is abandoned and a late ack must not retire anything.
    @(posedge clk); #1;
    valid_i = 1; alu_i = 32'h20; rw_i = 1; m2r_i = 1; mr_i = 1; instr_i = {17'h0, 3'b010, 12'h0}; rdaddr_i = 5'd9;
    @(negedge clk);
    chk("rst_busy.stall_idle", 32'(stall_o), 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_busy.req_busy", 32'(req_o), 32'h1);
    chk("rst_busy.stall_busy", 32'(stall_o), 32'h1);
    @(posedge clk); #1;
    rst = 1;
    clear_inputs();
    @(posedge clk); #1;
    rst = 0;
    ack_i = 1; rdata_i = 32'hFFFFFFFF;
    @(negedge clk);
    chk("rst_busy.req_after", 32'(req_o), 32'h0);
    chk("rst_busy.we_after", 32'(we_o), 32'h0);
    chk("rst_busy.addr_after", addr_o, 32'h0);
    chk("rst_busy.stall_after", 32'(stall_o), 32'h0);
    chk("rst_busy.valid_after", 32'(valid_o), 32'h0);
    @(posedge clk); #1;
    ack_i = 0;
    @(negedge clk);
    chk("rst_busy.late_ack_valid", 32'(valid_o), 32'h0);
    chk("rst_busy.late_ack_memdata", memdata_o, 32'h0);
    chk("rst_busy.late_ack_regwrite", 32'(rw_o), 32'h0);
    chk("rst_busy.late_ack_rdaddr", 32'(rdaddr_o), 32'h0);
    chk("rst_busy.late_ack_buserr", 32'(berr_o), 32'h0);
    chk("rst_busy.late_ack_req", 32'(req_o), 32'h0);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global guard so a wedged run still ends with a verdict.
  initial begin
    #200000;
    $display("FAIL global_timeout: got still-running expected finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage engine that consumes the EX/MEM pipeline register outputs and runs loads and stores against a data memory over a req/ack handshake. It also produces the MEM/WB-side outputs.
- Stalls the upstream pipeline while a memory access is outstanding.
- Sign- or zero-extends load data and generates byte enables for stores.
- Non-memory instructions pass through with one cycle of latency.

Parameters:
TIMEOUT_CYCLES, 16, number of BUSY cycles without dmem_ack_i before the access aborts; 0 disables the timeout.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, synchronous, active-high
valid_i  in  1  EX/MEM holds a valid instruction
ALUResult_i  in  32  effective address, or ALU result for non-memory ops
VALUResult_i  in  32  vector ALU result, passed through
RDData_i  in  32  store data
RDaddr_i  in  5  destination register
RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i  in  1 each  control bits from EX/MEM
instr_i  in  32  instruction; funct3 = instr_i[14:12]
dmem_req_o  out  1  memory request
dmem_we_o  out  1  1 = store
dmem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
dmem_wdata_o  out  32  store data, lane-shifted
dmem_be_o  out  4  byte enables
dmem_ack_i  in  1  memory completes the access this cycle
dmem_rdata_i  in  32  read word, valid with ack
stall_o  out  1  upstream must hold EX/MEM contents
valid_o  out  1  MEM/WB entry valid
RegWrite_o, MemToReg_o  out  1 each  registered control
RDaddr_o  out  5  registered destination register
ALUResult_o, VALUResult_o  out  32 each  registered pass-through
MemData_o  out  32  extended load data
misalign_o  out  1  one-cycle pulse: misaligned access dropped
bus_err_o  out  1  one-cycle pulse: access timed out

Behaviour:
- Reset:
  - Reset is synchronous and active-high (rst_i); all logic is clocked by clk_i. This is fixed.
  - Every registered output resets to 0; state goes to IDLE and the timeout counter clears.
  - A reset mid-access abandons the access: dmem_req_o is 0 from the next cycle, and a late dmem_ack_i in IDLE is ignored.
- mem_op = valid_i & (MemRead_i | MemWrite_i). If both are set, it is treated as a load.
- Misalignment:
  - Halfword access is misaligned when addr[0] = 1.
  - Word access is misaligned when addr[1:0] != 0.
- FSM states: IDLE, BUSY.
- IDLE, with no mem_op, or with a misaligned mem_op:
  - Registers all pass-through outputs next edge; valid_o = valid_i; stall_o = 0.
  - For a misaligned access: RegWrite_o = 0, misalign_o = 1 for one cycle, no memory request issued.
- IDLE, with an aligned mem_op:
  - stall_o = 1 combinationally; go to BUSY next edge.
  - Latch address, wdata, be, we and funct3 internally; valid_o = 0 (bubble).
- BUSY:
  - dmem_req_o = 1, with address, data, we and be driven from the latched values.
  - stall_o = ~dmem_ack_i & ~timeout_hit.
- BUSY, on dmem_ack_i:
  - Next edge: valid_o = 1; MemData_o = extended load data (0 for stores); go to IDLE.
  - Upstream advances on the same edge.
- BUSY, timeout: when the counter reaches TIMEOUT_CYCLES-1 without ack, treat as completion with RegWrite_o = 0 and bus_err_o pulsed.
- Minimum latency:
  - Memory op: 2 cycles (ack arrives in the first BUSY cycle).
  - Non-memory op: 1 cycle.
- Load extraction: byte/half selected by addr[1:0].
  - LB 000: sign-extend byte.
  - LH 001: sign-extend half.
  - LW 010: full word.
  - LBU 100: zero-extend byte.
  - LHU 101: zero-extend half.
  - Any other funct3 behaves as LW.
- Store lanes:
  - SB: be = 0001 << addr[1:0]; data replicated across 4 lanes.
  - SH: be = 0011 << addr[1:0]; data replicated across 2 lanes.
  - SW: be = 1111.
- Outside BUSY: dmem_req_o = 0 and dmem_we_o = 0.

Decomposition:
Shared package mem_pkg holds:
- funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
- FSM state encoding.

One sub-module, load_store_align, is natural. It is purely combinational:
- be/wdata generation.
- Misalign detection.
- Load extension.

Test Plan:
- ADD-type op (RegWrite_i = 1, ALUResult_i = 0x1234) -> next cycle valid_o = 1, ALUResult_o = 0x1234, stall_o never asserted.
- LB at 0x103 with dmem_rdata_i = 0x80FF_FF00 and ack after 3 BUSY cycles:
  - stall_o = 1 for 4 cycles.
  - Then MemData_o = 0xFFFFFF80 and valid_o = 1.
- LBU at the same address and data -> MemData_o = 0x00000080.
- SH at 0x102 with RDData_i = 0xABCD -> dmem_be_o = 1100, dmem_wdata_o = 0xABCDABCD, dmem_we_o = 1, dmem_addr_o = 0x100.
- LW at 0x102 -> no dmem_req_o, misalign_o pulse, RegWrite_o = 0, no stall.
- Two scenarios with TIMEOUT_CYCLES = 4:
  - No ack -> bus_err_o pulses after 4 BUSY cycles and stall_o releases.
  - Separately, rst_i asserted in BUSY -> dmem_req_o = 0 next cycle, a late ack is ignored, and all outputs are 0.
